// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC datapath: width, ALU/shift codes and
// the execute-stage FSM encoding.
package risc_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } exec_state_e;

endpackage

// File: rtl/exec_shifter.sv
// Combinational one-bit shifter applied to the B operand of the execute stage.
module exec_shifter
    import risc_pkg::*;
#(
    parameter int WIDTH = risc_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] bsh
);

    always_comb begin
        bsh = b;
        case (shift_e'(shift))
            SH_NONE: bsh = b;
            SH_LSL1: bsh = {b[WIDTH-2:0], 1'b0};
            SH_LSR1: bsh = {1'b0, b[WIDTH-1:1]};
            SH_ASR1: bsh = {b[WIDTH-1], b[WIDTH-1:1]};
            default: bsh = b;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Operand latch, shift and ALU stage feeding register write-back.
// Build option: define EXEC_NV_FLAGS_EN to compute the N and V status flags.
module execute_stage
    import risc_pkg::*;
#(
    parameter int WIDTH = risc_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rd_a,
    input  logic [WIDTH-1:0] rd_b,
    input  logic [WIDTH-1:0] imm,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       shift,
    input  logic [1:0]       aluop,
    input  logic [2:0]       writenum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       status,
    output logic [2:0]       writenum,
    output logic             write
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. Once out_valid rises, C/status/writenum/write stay stable
    // until out_ready is seen; valid never depends combinationally on ready.

    exec_state_e      state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       shift_q;
    logic [1:0]       aluop_q;
    logic [2:0]       wn_q;
    logic [WIDTH-1:0] bsh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic [1:0]       flags_vn;
    logic             accept;

    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    exec_shifter #(.WIDTH(WIDTH)) u_shifter (
        .b     (b_q),
        .shift (shift_q),
        .bsh   (bsh)
    );

    assign sum  = a_q + bsh;
    assign diff = a_q - bsh;

    always_comb begin
        result = sum;
        case (aluop_e'(aluop_q))
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_AND: result = a_q & bsh;
            ALU_MVN: result = ~bsh;
            default: result = sum;
        endcase
    end

`ifdef EXEC_NV_FLAGS_EN
    logic v_flag;

    // Overflow: operands agree in sign (ADD) or differ (SUB) and result sign flips.
    always_comb begin
        v_flag = 1'b0;
        case (aluop_e'(aluop_q))
            ALU_ADD: v_flag = (a_q[WIDTH-1] == bsh[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            ALU_SUB: v_flag = (a_q[WIDTH-1] != bsh[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            default: v_flag = 1'b0;
        endcase
    end

    assign flags_vn = {v_flag, result[WIDTH-1]};
`else
    assign flags_vn = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shift_q  <= '0;
            aluop_q  <= '0;
            wn_q     <= '0;
            C        <= '0;
            status   <= '0;
            writenum <= '0;
            write    <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= asel ? '0 : rd_a;
                b_q     <= bsel ? imm : rd_b;
                shift_q <= shift;
                aluop_q <= aluop;
                wn_q    <= writenum_in;
            end
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_EXEC;
                end
                S_EXEC: begin
                    C        <= result;
                    status   <= {flags_vn, (result == '0)};
                    writenum <= wn_q;
                    write    <= (aluop_e'(aluop_q) != ALU_SUB);
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= accept ? S_EXEC : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage; honours EXEC_NV_FLAGS_EN in its model.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [15:0] imm;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [2:0]  writenum_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C;
  logic [2:0]  status;
  logic [2:0]  writenum;
  logic        write;

  int checks;
  int failures;

  // expected result packing: {C[15:0], V, N, Z, write, writenum[2:0]}
  logic [22:0] exp_q[$];

  execute_stage #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rd_a        (rd_a),
    .rd_b        (rd_b),
    .imm         (imm),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .aluop       (aluop),
    .writenum_in (writenum_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .C           (C),
    .status      (status),
    .writenum    (writenum),
    .write       (write)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: integer arithmetic straight from the operation rules
  function automatic logic [22:0] model(input logic [15:0] a_in, input logic [15:0] b_in,
                                        input logic [15:0] imm_v, input logic asel_v,
                                        input logic bsel_v, input logic [1:0] sh,
                                        input logic [1:0] op, input logic [2:0] wn);
    int a, b, bs, sa, sb, full, r;
    logic v, n, z, wr;
    logic [15:0] r16;
    a = asel_v ? 0 : int'(a_in);
    b = bsel_v ? int'(imm_v) : int'(b_in);
    case (sh)
      2'd0: bs = b;
      2'd1: bs = (b * 2) % 65536;
      2'd2: bs = b / 2;
      default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (bs >= 32768) ? bs - 65536 : bs;
    v = 1'b0;
    case (op)
      2'd0, 2'd1: begin
        full = (op == 2'd0) ? sa + sb : sa - sb;
        v = (full > 32767) || (full < -32768);
        r = (full + 131072) % 65536;
      end
      2'd2: r = a & bs;
      default: r = 65535 - bs;
    endcase
    r16 = r[15:0];
    n = (r >= 32768);
    z = (r == 0);
    wr = (op != 2'd1);
`ifndef EXEC_NV_FLAGS_EN
    n = 1'b0;
    v = 1'b0;
`endif
    return {r16, v, n, z, wr, wn};
  endfunction

  // driver tasks
  task automatic drive_idle();
    in_valid = 1'b0; rd_a = '0; rd_b = '0; imm = '0; asel = 1'b0; bsel = 1'b0;
    shift = '0; aluop = '0; writenum_in = '0;
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] im,
                          input logic as, input logic bs, input logic [1:0] sh,
                          input logic [1:0] op, input logic [2:0] wn);
    in_valid = 1'b1; rd_a = a; rd_b = b; imm = im; asel = as; bsel = bs;
    shift = sh; aluop = op; writenum_in = wn;
  endtask

  task automatic drive_random();
    drive_op(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compares DUT outputs against the head of exp_q
  task automatic check_result(input string name);
    logic [22:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    if (out_valid !== 1'b1 || C !== e[22:7] || status !== e[6:4] || write !== e[3] ||
        writenum !== e[2:0]) begin
      failures++;
      $display("FAIL %s: got valid=%b C=%h status=%b write=%b wn=%0d, expected valid=1 C=%h status=%b write=%b wn=%0d",
               name, out_valid, C, status, write, writenum, e[22:7], e[6:4], e[3], e[2:0]);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_idle();
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (C !== 16'h0 || status !== 3'b0 || writenum !== 3'd0 || write !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: C=%h status=%b wn=%0d write=%b, expected all 0", C, status, writenum, write);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  // single op from IDLE with out_ready high; returns to IDLE afterwards
  task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] im, input logic as, input logic bs,
                            input logic [1:0] sh, input logic [1:0] op, input logic [2:0] wn);
    out_ready = 1'b1;
    drive_op(a, b, im, as, bs, sh, op, wn);
    exp_q.push_back(model(a, b, im, as, bs, sh, op, wn));
    tick();
    drive_idle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_exec: out_valid=%b in_ready=%b, expected 0/0", name, out_valid, in_ready);
    end
    tick();
    check_result(name);
  endtask

  task automatic test_directed();
    run_single("add_lsl", 16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b00, 3'd5);
    checks++;
    if (C !== 16'h000B || writenum !== 3'd5 || write !== 1'b1 || status[0] !== 1'b0) begin
      failures++;
      $display("FAIL add_const: C=%h wn=%0d write=%b Z=%b, expected 000b 5 1 0", C, writenum, write, status[0]);
    end
    tick();
    run_single("sub_ovf", 16'h7FFF, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 2'b00, 2'b01, 3'd2);
    checks++;
`ifdef EXEC_NV_FLAGS_EN
    if (C !== 16'h8000 || status !== 3'b110 || write !== 1'b0) begin
`else
    if (C !== 16'h8000 || status !== 3'b000 || write !== 1'b0) begin
`endif
      failures++;
      $display("FAIL sub_const: C=%h status=%b write=%b", C, status, write);
    end
    tick();
    run_single("mvn_asr", 16'h1111, 16'h8000, 16'h0000, 1'b0, 1'b0, 2'b11, 2'b11, 3'd1);
    checks++;
    if (C !== 16'h3FFF) begin
      failures++;
      $display("FAIL mvn_const: C=%h, expected 3fff", C);
    end
    tick();
    run_single("and_asel", 16'h00F0, 16'h0FF0, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b10, 3'd7);
    checks++;
    if (C !== 16'h0000 || status[0] !== 1'b1) begin
      failures++;
      $display("FAIL and_const: C=%h Z=%b, expected 0000 1", C, status[0]);
    end
    tick();
    run_single("lsr_add", 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 2'b10, 2'b00, 3'd3);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL retire_idle: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] c_hold;
    run_single("bp_first", 16'h1234, 16'h0101, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd4);
    out_ready = 1'b0;
    c_hold = 16'h1234 + 16'h0101;
    drive_op(16'h0F00, 16'h00FF, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b01, 3'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || C !== c_hold || writenum !== 3'd4) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b in_ready=%b C=%h wn=%0d, expected 1 0 %h 4",
                 i, out_valid, in_ready, C, writenum, c_hold);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready: in_ready=%b, expected 1", in_ready);
    end
    exp_q.push_back(model(16'h0F00, 16'h00FF, 16'h0000, 1'b0, 1'b0, 2'b01, 2'b01, 3'd6));
    tick();
    drive_idle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_gap: out_valid=%b, expected 0", out_valid);
    end
    tick();
    check_result("bp_second");
    tick();
  endtask

  // continuous stream, in_valid held high including a decoy op during EXEC
  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_random();
      exp_q.push_back(model(rd_a, rd_b, imm, asel, bsel, shift, aluop, writenum_in));
      tick();
      drive_random();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_exec%0d: out_valid=%b in_ready=%b, expected 0/0", i, out_valid, in_ready);
      end
      tick();
      check_result($sformatf("b2b_%0d", i));
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    drive_op(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'd3);
    tick();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || C !== 16'h0 || status !== 3'b0 || writenum !== 3'd0 ||
          write !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_exec%0d: valid=%b C=%h status=%b wn=%0d write=%b in_ready=%b",
                 i, out_valid, C, status, writenum, write, in_ready);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive_idle();
    out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected: %0d entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Operand-latch, shift and ALU stage of the 16-bit RISC datapath, sitting directly upstream of the register write-back stage. Accepts two register-file operands plus decoded control, shifts operand B, performs the ALU operation, and registers the result `C`, status flags and the destination register number. A valid/ready handshake on both sides lets the write-back stage stall the datapath.

## Interface
Parameters:
- `WIDTH`, 16: datapath width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `rd_a`  in  WIDTH  register-file operand A.
- `rd_b`  in  WIDTH  register-file operand B.
- `imm`  in  WIDTH  sign-extended immediate.
- `asel`  in  1  1: A operand forced to 0.
- `bsel`  in  1  1: B operand taken from `imm` instead of `rd_b`.
- `shift`  in  2  shift applied to B: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- `aluop`  in  2  00 ADD, 01 SUB/compare, 10 AND, 11 MVN (~B).
- `writenum_in`  in  3  destination register.
- `out_valid`  out  1  `C`, `status`, `writenum`, `write` are valid.
- `out_ready`  in  1  write-back stage consumes the result.
- `C`  out  WIDTH  registered result.
- `status`  out  3  {V, N, Z}.
- `writenum`  out  3  registered destination register.
- `write`  out  1  1: write-back must write `C`; 0 for compare.

## Operation
- FSM states: IDLE, EXEC, DONE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready); combinational from state and `out_ready` only.
- Accept = `in_valid && in_ready`: latch A (0 if `asel`), B (`imm` if `bsel` else `rd_b`), `shift`, `aluop`, `writenum_in`; next state EXEC.
- EXEC: Bsh = shift(B); compute result; register `C`, `status`, `writenum`, `write`; next state DONE.
- DONE: `out_valid`=1, all outputs held stable until `out_ready`. On `out_ready`: next state EXEC if a new op is accepted the same cycle, else IDLE.
- Arithmetic: WIDTH-bit, carry-out discarded. SUB = A − Bsh.
- Z = (result==0); N = result[WIDTH-1]; V = signed overflow for ADD/SUB, 0 for AND/MVN.
- `write` = 0 when `aluop`==SUB (compare); `C` still updated with the difference.
- `status` updated on every executed operation.
- Shifts are by exactly one bit; LSL1 drops MSB, LSR1 inserts 0, ASR1 replicates MSB.

## Timing
- Reset: state IDLE; `C`=0, `status`=0, `writenum`=0, `write`=0, `out_valid`=0; `in_ready`=1 in the first cycle after reset.
- Latency: accept at edge N → `out_valid`=1 after edge N+1.
- Throughput: one operation per 2 cycles when `out_ready` is held high.
- Back-pressure: with `out_ready`=0, DONE holds indefinitely; `in_ready`=0, inputs ignored.
- Simultaneous consume and accept in DONE: old result retires, new op enters EXEC; `out_valid` deasserts for exactly one cycle.
- Reset mid-operation (EXEC or DONE): operation discarded, no `out_valid` pulse; reset has priority over any handshake.
- `in_valid` while in EXEC: not accepted (`in_ready`=0).

## Configuration
- `EXEC_NV_FLAGS_EN` defined: N and V computed as above.
- Undefined: `status[2:1]` tied to 0, no overflow logic; Z behaviour unchanged.

## Structure
- Shared package `risc_pkg`: `WIDTH` constant, aluop codes, shift codes, FSM state encoding.
- One sub-module `exec_shifter` (combinational WIDTH-bit one-bit shifter); ALU, operand latches and FSM live in `execute_stage`.

## Test plan
- Reset then idle: `C`=0, `status`=0, `out_valid`=0, `in_ready`=1.
- ADD rd_a=0x0003, rd_b=0x0004, shift=01, writenum_in=5 → after 2 edges `C`=0x000B, `writenum`=5, `write`=1, Z=0.
- SUB rd_a=0x7FFF, bsel=1, imm=0xFFFF, shift=00 → `C`=0x8000, N=1, V=1, `write`=0 (with macro); N=V=0 without.
- MVN rd_b=0x8000, shift=11 → Bsh=0xC000, `C`=0x3FFF; AND rd_a=0x00F0, rd_b=0x0FF0, asel=1 → `C`=0, Z=1.
- Hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 → outputs stable, `in_ready`=0; raise `out_ready` → new op accepted same cycle, result after 2 edges.
- Assert `reset` in EXEC → next cycle IDLE, `out_valid` never rises, outputs 0.
